// File: rtl/falu_int2fp_cvt.sv
// rtl/falu_int2fp_cvt.sv - iterative integer to IEEE-754 SP/DP converter with RISC-V rounding
module falu_int2fp_cvt #(
    parameter int NORM_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] INPUT,
    input  logic        IsDouble,
    input  logic        IsLong,
    input  logic        IsUnsigned,
    input  logic [2:0]  rm,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] OUTPUT,
    output logic [4:0]  fflags
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [63:0] r_mag;
    logic [7:0]  r_e;
    logic        r_sign;
    logic [2:0]  r_rm;
    logic        r_dp;
    logic [63:0] r_out;
    logic [4:0]  r_fflags;
    logic        r_out_valid;

    logic [63:0] w_val;
    logic        w_sign;
    logic [63:0] w_mag;
    logic        w_g;
    logic        w_s;
    logic        w_lsb;
    logic        w_inc;
    logic [23:0] w_sp_sum;
    logic [52:0] w_dp_sum;
    logic        w_carry;
    logic [7:0]  w_e_rnd;
    logic [7:0]  w_exp_sp;
    logic [10:0] w_exp_dp;
    logic [63:0] w_result;
    logic        w_zero;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign OUTPUT    = r_out;
    assign fflags    = r_fflags;

    // Operand extension and magnitude extraction at accept time
    always_comb begin
        w_val = 64'd0;
        if (IsLong)
            w_val = INPUT;
        else if (IsUnsigned)
            w_val = {32'd0, INPUT[31:0]};
        else
            w_val = {{32{INPUT[31]}}, INPUT[31:0]};
        w_sign = ~IsUnsigned & w_val[63];
        w_mag  = w_sign ? (~w_val + 64'd1) : w_val;
    end

    // Rounding of the normalized magnitude and result packing
    always_comb begin
        w_zero = (r_mag == 64'd0);
        if (r_dp) begin
            w_g   = r_mag[10];
            w_s   = |r_mag[9:0];
            w_lsb = r_mag[11];
        end else begin
            w_g   = r_mag[39];
            w_s   = |r_mag[38:0];
            w_lsb = r_mag[40];
        end
        case (r_rm)
            3'b001:  w_inc = 1'b0;
            3'b010:  w_inc = r_sign & (w_g | w_s);
            3'b011:  w_inc = ~r_sign & (w_g | w_s);
            3'b100:  w_inc = w_g;
            default: w_inc = w_g & (w_s | w_lsb);
        endcase
        w_sp_sum = {1'b0, r_mag[62:40]} + {23'd0, w_inc};
        w_dp_sum = {1'b0, r_mag[62:11]} + {52'd0, w_inc};
        // A carry out of the fraction leaves an all-zero fraction and bumps the exponent
        w_carry  = r_dp ? w_dp_sum[52] : w_sp_sum[23];
        w_e_rnd  = r_e + {7'd0, w_carry};
        w_exp_sp = w_e_rnd + 8'd127;
        w_exp_dp = {3'd0, w_e_rnd} + 11'd1023;
        if (w_zero)
            w_result = r_dp ? 64'd0 : {32'hFFFF_FFFF, 32'd0};
        else if (r_dp)
            w_result = {r_sign, w_exp_dp, w_dp_sum[51:0]};
        else
            w_result = {32'hFFFF_FFFF, r_sign, w_exp_sp, w_sp_sum[22:0]};
    end

    // Control FSM and datapath registers; flush overrides every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mag       <= 64'd0;
            r_e         <= 8'd0;
            r_sign      <= 1'b0;
            r_rm        <= 3'd0;
            r_dp        <= 1'b0;
            r_out       <= 64'd0;
            r_fflags    <= 5'd0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mag   <= w_mag;
                        r_sign  <= w_sign;
                        r_rm    <= rm;
                        r_dp    <= IsDouble;
                        r_e     <= 8'd63;
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    if (r_mag == 64'd0 || r_mag[63]) begin
                        r_state <= ROUND;
                    end else if (r_mag[63 -: NORM_STEP] == '0) begin
                        r_mag <= r_mag << NORM_STEP;
                        r_e   <= r_e - 8'(NORM_STEP);
                    end else begin
                        r_mag <= r_mag << 1;
                        r_e   <= r_e - 8'd1;
                    end
                end
                ROUND: begin
                    r_out       <= w_result;
                    r_fflags    <= {4'd0, ~w_zero & (w_g | w_s)};
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_falu_int2fp_cvt.sv
// tb/tb_falu_int2fp_cvt.sv - directed self-checking bench for falu_int2fp_cvt
module tb_falu_int2fp_cvt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] INPUT;
    logic        IsDouble;
    logic        IsLong;
    logic        IsUnsigned;
    logic [2:0]  rm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] OUTPUT;
    logic [4:0]  fflags;

    int checks = 0;
    int errors = 0;

    falu_int2fp_cvt #(.NORM_STEP(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .INPUT      (INPUT),
        .IsDouble   (IsDouble),
        .IsLong     (IsLong),
        .IsUnsigned (IsUnsigned),
        .rm         (rm),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .OUTPUT     (OUTPUT),
        .fflags     (fflags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Accept one operand, wait (bounded) for out_valid, check latency, result and flags
    task automatic conv(input string tag, input logic [63:0] val, input logic dbl, input logic lng,
                        input logic uns, input logic [2:0] mode, input logic [63:0] exp_out,
                        input logic [4:0] exp_flags, input int exp_edges);
        int n;
        INPUT      = val;
        IsDouble   = dbl;
        IsLong     = lng;
        IsUnsigned = uns;
        rm         = mode;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_edges));
        chk({tag, "_out"}, OUTPUT, exp_out);
        chk({tag, "_flags"}, 64'(fflags), 64'(exp_flags));
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_idle"}, 64'({out_valid, in_ready}), 64'b01);
        end
    endtask

    initial begin
        logic [63:0] held_out;
        logic [4:0]  held_flags;
        logic        seen_valid;

        rst_n = 1'b0; in_valid = 1'b0; INPUT = 64'd0; IsDouble = 1'b0; IsLong = 1'b0;
        IsUnsigned = 1'b0; rm = 3'd0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("reset_out", OUTPUT, 64'd0);
        chk("reset_flags", 64'(fflags), 64'd0);
        chk("reset_valid_ready", 64'({out_valid, in_ready}), 64'b01);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        conv("sw_one",       64'h1,                  0, 0, 0, 3'b000, 64'hFFFFFFFF_3F800000, 5'd0, 16);
        conv("dl_min",       64'h8000_0000_0000_0000, 1, 1, 0, 3'b000, 64'hC3E0_0000_0000_0000, 5'd0, 2);
        conv("swu_max_rne",  64'hFFFF_FFFF,          0, 0, 1, 3'b000, 64'hFFFFFFFF_4F800000, 5'd1, 6);
        conv("swu_max_rtz",  64'hFFFF_FFFF,          0, 0, 1, 3'b001, 64'hFFFFFFFF_4F7FFFFF, 5'd1, 6);
        conv("sl_rdn",       64'hFFFF_FFFF_FEFF_FFFF, 0, 1, 0, 3'b010, 64'hFFFFFFFF_CB800001, 5'd1, 13);
        conv("sl_rup",       64'hFFFF_FFFF_FEFF_FFFF, 0, 1, 0, 3'b011, 64'hFFFFFFFF_CB800000, 5'd1, 13);
        conv("sl_rne",       64'hFFFF_FFFF_FEFF_FFFF, 0, 1, 0, 3'b000, 64'hFFFFFFFF_CB800000, 5'd1, 13);
        conv("sl_rmm",       64'hFFFF_FFFF_FEFF_FFFF, 0, 1, 0, 3'b100, 64'hFFFFFFFF_CB800001, 5'd1, 13);
        conv("sl_rm111",     64'hFFFF_FFFF_FEFF_FFFF, 0, 1, 0, 3'b111, 64'hFFFFFFFF_CB800000, 5'd1, 13);
        conv("s_zero_rdn",   64'h0,                  0, 0, 0, 3'b010, 64'hFFFFFFFF_00000000, 5'd0, 2);
        conv("dw_neg3",      64'hFFFF_FFFF_FFFF_FFFD, 1, 0, 0, 3'b000, 64'hC008_0000_0000_0000, 5'd0, 15);
        conv("dwu_neg_word", 64'h0000_0000_8000_0000, 1, 0, 1, 3'b000, 64'h41E0_0000_0000_0000, 5'd0, 6);

        // Back-pressure: result must hold while out_ready is low
        out_ready = 1'b0;
        conv("hold", 64'hFFFF_FFFF, 0, 0, 1, 3'b001, 64'hFFFFFFFF_4F7FFFFF, 5'd1, 6);
        held_out   = OUTPUT;
        held_flags = fflags;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_out_%0d", i), OUTPUT, 64'hFFFFFFFF_4F7FFFFF);
            chk($sformatf("hold_flags_%0d", i), 64'(fflags), 64'(held_flags));
            chk($sformatf("hold_valid_ready_%0d", i), 64'({out_valid, in_ready}), 64'b10);
        end
        chk("hold_same", OUTPUT, held_out);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release", 64'({out_valid, in_ready}), 64'b01);

        // Flush during NORM discards the operation
        INPUT = 64'h1; IsDouble = 1'b0; IsLong = 1'b0; IsUnsigned = 1'b0; rm = 3'b000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("flush_busy", 64'(in_ready), 64'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", 64'(in_ready), 64'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("flush_no_valid", 64'(seen_valid), 64'd0);
        chk("flush_flags_kept", 64'(fflags), 64'(held_flags));

        // Flush together with in_valid in IDLE: no accept
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_blocked", 64'(in_ready), 64'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("flush_accept_no_valid", 64'(seen_valid), 64'd0);

        // Asynchronous reset in the middle of NORM
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out", OUTPUT, 64'd0);
        chk("arst_flags", 64'(fflags), 64'd0);
        chk("arst_valid_ready", 64'({out_valid, in_ready}), 64'b01);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("arst_no_partial", 64'(seen_valid), 64'd0);

        conv("post_reset", 64'h1, 0, 0, 0, 3'b000, 64'hFFFFFFFF_3F800000, 5'd0, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
